color_frame_loader: RTL and testbench
=====================================

Name: color_frame_loader

Overview:
- Parametrised frame loader feeding the colour BRAM write port.
- Replaces per-pixel register pokes with a streamed path: accepts raw RGB pixels on a valid/ready interface and packs/quantises each channel.
- Generates raster addresses and issues one BRAM write request per pixel, holding it until the write-done acknowledge.
- Signals frame completion, ack timeout and abort; sits between the AXI-lite slave pixel path and the COLOR_BRAM write interface.

Parameters:
- CHANNELS, 3, colour channels per pixel.
- IN_CH_W, 8, input bits per channel.
- OUT_CH_W, 4, output bits per channel (must be ≤ IN_CH_W).
- IMG_W, 320, pixels per line.
- IMG_H, 240, lines per frame.
- ADDR_W, 17, BRAM address width (must hold IMG_W*IMG_H).
- ACK_TIMEOUT, 255, max WAIT_ACK cycles before error; 0 disables timeout.

Ports:
- i_CLK  in  1  clock.
- i_RST  in  1  reset.
- i_START  in  1  start-frame pulse.
- i_ABORT  in  1  abort current frame.
- i_MODE  in  1  quantiser: 0 truncate, 1 round-half-up with saturation.
- i_PIX_DATA  in  CHANNELS*IN_CH_W  input pixel; channel 0 in LSBs.
- i_PIX_VALID  in  1  input pixel valid.
- o_PIX_READY  out  1  loader accepts pixel.
- o_WRDATA  out  CHANNELS*OUT_CH_W  packed pixel; channel 0 in LSBs.
- o_WRADDR  out  ADDR_W  BRAM write address.
- o_WRREQ  out  1  write request, level-held until ack.
- i_WRDONE  in  1  BRAM write-done acknowledge.
- o_BUSY  out  1  frame in progress.
- o_FRAME_DONE  out  1  one-cycle pulse at end of frame.
- o_PIX_COUNT  out  ADDR_W  pixels acknowledged in the current/last frame.
- o_ERR  out  1  sticky ack-timeout flag.

Behaviour:
- Single clock i_CLK; reset i_RST is synchronous and active-high.
- Reset values: all outputs 0; FSM in IDLE.
- FSM states: IDLE, ACCEPT, WAIT_ACK, DONE.
- IDLE:
  - i_START=1 and i_ABORT=0 → ACCEPT next cycle.
  - On that transition: o_PIX_COUNT, o_WRADDR and o_ERR clear to 0; o_BUSY goes 1.
- ACCEPT:
  - o_PIX_READY=1 (registered; asserted only in this state).
  - i_PIX_VALID=1 at an edge: quantise and register data, then → WAIT_ACK.
  - Latency: o_WRREQ=1 with stable o_WRDATA/o_WRADDR in the cycle after the handshake edge.
  - i_PIX_VALID=0: hold, nothing captured.
- WAIT_ACK:
  - o_WRREQ=1; o_WRDATA and o_WRADDR held constant.
  - i_WRDONE is sampled at every edge, including the first WRREQ cycle.
  - On ack: o_PIX_COUNT += 1.
  - If that pixel's address == IMG_W*IMG_H-1 → DONE.
  - Otherwise o_WRADDR += 1 → ACCEPT.
  - o_WRREQ drops in the cycle after the ack edge.
  - i_WRDONE outside WAIT_ACK is ignored.
- DONE: lasts one cycle; o_FRAME_DONE=1; o_BUSY=0 next; → IDLE with o_WRADDR=0; o_PIX_COUNT retained.
- i_START while not IDLE: ignored.
- i_ABORT in any non-IDLE state:
  - → IDLE next cycle; o_WRREQ, o_PIX_READY and o_BUSY go 0; o_WRADDR resets to 0.
  - No o_FRAME_DONE; o_PIX_COUNT retained; o_ERR unchanged.
  - Abort beats a simultaneous ack (count not incremented) and a simultaneous i_START in IDLE.
- Timeout (ACK_TIMEOUT>0):
  - Counter clears on entry to WAIT_ACK and increments each WAIT_ACK cycle without ack.
  - When it reaches ACK_TIMEOUT without ack: o_ERR=1 (sticky until next accepted i_START), → IDLE, no frame_done.
  - An ack on the same edge as the limit wins.
- Quantiser, per channel c = IN_CH_W-bit field, D = IN_CH_W-OUT_CH_W:
  - Truncate: out = c[IN_CH_W-1 -: OUT_CH_W].
  - Round: s = c + 2^(D-1) in IN_CH_W+1 bits; out = top OUT_CH_W bits of s, saturated to all-ones if s[IN_CH_W]=1.
  - D=0: pass-through in both modes.
- i_MODE is sampled at the pixel handshake edge.

Test Plan:
- Bench parameters IMG_W=4, IMG_H=2, ACK_TIMEOUT=16, i_WRDONE stuck 0 → outputs all 0 until start; after i_START, o_BUSY=1, o_PIX_READY=1 next cycle.
- Quantiser, pixel 24'hF718A5 at address 0:
  - i_MODE=0 → o_WRDATA=12'hF1A.
  - i_MODE=1 → o_WRDATA=12'hF2A.
  - i_MODE=1, 24'hF8F8F8 → 12'hFFF (saturation).
  - i_MODE=1, 24'h070707 → 12'h000.
- Full frame, ack on the first WRREQ cycle → o_WRADDR sequence 0..7; o_FRAME_DONE high exactly one cycle after the 8th ack; o_PIX_COUNT=8; o_BUSY=0 afterwards.
- Ack delayed 3 cycles and i_PIX_VALID gapped → o_WRREQ held 3 cycles with o_WRDATA/o_WRADDR constant; no capture while o_PIX_READY=0; frame still ends at count 8.
- i_ABORT on the same edge as the 4th pixel's ack → IDLE next cycle; o_PIX_COUNT=3; no o_FRAME_DONE; the next i_START writes from address 0.
- No ack for 16 WAIT_ACK cycles → o_ERR=1, o_WRREQ=0, IDLE.
- Timeout variants:
  - Ack on the 16th edge → no error.
  - Next i_START clears o_ERR.

Source files
------------

// File: rtl/color_frame_loader.sv
// Colour frame loader: streams RGB pixels, quantises each channel and
// issues one level-held BRAM write per pixel in raster order.
module color_frame_loader #(
    parameter int CHANNELS    = 3,
    parameter int IN_CH_W     = 8,
    parameter int OUT_CH_W    = 4,
    parameter int IMG_W       = 320,
    parameter int IMG_H       = 240,
    parameter int ADDR_W      = 17,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                         i_CLK,
    input  logic                         i_RST,
    input  logic                         i_START,
    input  logic                         i_ABORT,
    input  logic                         i_MODE,
    input  logic [CHANNELS*IN_CH_W-1:0]  i_PIX_DATA,
    input  logic                         i_PIX_VALID,
    output logic                         o_PIX_READY,
    output logic [CHANNELS*OUT_CH_W-1:0] o_WRDATA,
    output logic [ADDR_W-1:0]            o_WRADDR,
    output logic                         o_WRREQ,
    input  logic                         i_WRDONE,
    output logic                         o_BUSY,
    output logic                         o_FRAME_DONE,
    output logic [ADDR_W-1:0]            o_PIX_COUNT,
    output logic                         o_ERR
);

    localparam int D  = IN_CH_W - OUT_CH_W;
    localparam int DH = (D > 0) ? D - 1 : 0;
    localparam logic [IN_CH_W:0] HALF =
        (D > 0) ? ((IN_CH_W + 1)'(1) << DH) : '0;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMG_W * IMG_H - 1);
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TW-1:0] TLIM =
        TW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCEPT,
        S_WAIT_ACK,
        S_DONE
    } state_t;

    state_t                        state_q, state_d;
    logic [CHANNELS*OUT_CH_W-1:0]  data_q, data_d;
    logic [ADDR_W-1:0]             addr_q, addr_d;
    logic [ADDR_W-1:0]             cnt_q, cnt_d;
    logic [TW-1:0]                 tmr_q, tmr_d;
    logic                          err_q, err_d;
    logic [CHANNELS*OUT_CH_W-1:0]  q_data;

    // Rounding adds half an output LSB, then keeps the top bits plus carry.
    always_comb begin : quant
        logic [IN_CH_W-1:0]  ch;
        logic [OUT_CH_W:0]   s;
        q_data = '0;
        ch     = '0;
        s      = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            ch = i_PIX_DATA[c*IN_CH_W +: IN_CH_W];
            s  = (OUT_CH_W + 1)'(({1'b0, ch} + HALF) >> D);
            if (!i_MODE)
                q_data[c*OUT_CH_W +: OUT_CH_W] = ch[IN_CH_W-1 -: OUT_CH_W];
            else if (s[OUT_CH_W])
                q_data[c*OUT_CH_W +: OUT_CH_W] = '1;
            else
                q_data[c*OUT_CH_W +: OUT_CH_W] = s[OUT_CH_W-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
        err_d   = err_q;
        if (state_q != S_IDLE && i_ABORT) begin
            state_d = S_IDLE;
            addr_d  = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (i_START && !i_ABORT) begin
                        state_d = S_ACCEPT;
                        addr_d  = '0;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                    end
                end
                S_ACCEPT: begin
                    if (i_PIX_VALID) begin
                        data_d  = q_data;
                        tmr_d   = '0;
                        state_d = S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    if (i_WRDONE) begin
                        cnt_d = cnt_q + ADDR_W'(1);
                        if (addr_q == LAST) begin
                            state_d = S_DONE;
                        end else begin
                            addr_d  = addr_q + ADDR_W'(1);
                            state_d = S_ACCEPT;
                        end
                    end else if (ACK_TIMEOUT > 0 && tmr_q == TLIM) begin
                        err_d   = 1'b1;
                        addr_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        tmr_d = tmr_q + TW'(1);
                    end
                end
                S_DONE: begin
                    addr_d  = '0;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            tmr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            err_q   <= err_d;
        end
    end

    assign o_PIX_READY  = (state_q == S_ACCEPT);
    assign o_WRREQ      = (state_q == S_WAIT_ACK);
    assign o_FRAME_DONE = (state_q == S_DONE);
    assign o_BUSY       = (state_q != S_IDLE);
    assign o_WRDATA     = data_q;
    assign o_WRADDR     = addr_q;
    assign o_PIX_COUNT  = cnt_q;
    assign o_ERR        = err_q;

endmodule

// File: tb/tb_color_frame_loader.sv
// Scoreboard bench for color_frame_loader on a 4x2 frame with a
// 16-cycle ack timeout; a monitor also plays the BRAM ack side.
module tb_color_frame_loader;

    logic        clk = 1'b0;
    logic        i_RST, i_START, i_MODE, i_PIX_VALID, i_WRDONE;
    logic        abort_mon, abort_main, i_ABORT;
    logic [23:0] i_PIX_DATA;
    logic        o_PIX_READY, o_WRREQ, o_BUSY, o_FRAME_DONE, o_ERR;
    logic [11:0] o_WRDATA;
    logic [16:0] o_WRADDR, o_PIX_COUNT;

    typedef struct {
        logic [16:0] addr;
        logic [11:0] data;
        int          len;
        bit          ack;
        bit          abrt;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   fd_cnt = 0;

    assign i_ABORT = abort_mon | abort_main;

    always #5 clk = ~clk;

    color_frame_loader #(
        .IMG_W(4), .IMG_H(2), .ACK_TIMEOUT(16)
    ) dut (
        .i_CLK(clk), .i_RST(i_RST), .i_START(i_START), .i_ABORT(i_ABORT),
        .i_MODE(i_MODE), .i_PIX_DATA(i_PIX_DATA), .i_PIX_VALID(i_PIX_VALID),
        .o_PIX_READY(o_PIX_READY), .o_WRDATA(o_WRDATA), .o_WRADDR(o_WRADDR),
        .o_WRREQ(o_WRREQ), .i_WRDONE(i_WRDONE), .o_BUSY(o_BUSY),
        .o_FRAME_DONE(o_FRAME_DONE), .o_PIX_COUNT(o_PIX_COUNT), .o_ERR(o_ERR)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: pops the expected write on each new request, checks hold
    // stability and length, and drives the ack the entry asks for.
    initial begin
        exp_t        cur;
        bit          prev_req, last_ack, wr;
        int          reqcyc;
        logic [16:0] h_addr;
        logic [11:0] h_data;
        cur = '{addr: 0, data: 0, len: 0, ack: 0, abrt: 0};
        prev_req = 0; last_ack = 0; wr = 0; reqcyc = 0;
        h_addr = '0; h_data = '0;
        i_WRDONE = 1'b0;
        abort_mon = 1'b0;
        forever begin
            @(negedge clk);
            if (o_FRAME_DONE || last_ack)
                chk("frame_done", 32'(o_FRAME_DONE), 32'(last_ack));
            if (o_FRAME_DONE) fd_cnt++;
            if (o_WRREQ && !prev_req) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_wrreq: got addr %h expected none",
                             o_WRADDR);
                    cur = '{addr: 0, data: 0, len: 0, ack: 0, abrt: 0};
                end else begin
                    cur = sb.pop_front();
                    chk("wraddr", 32'(o_WRADDR), 32'(cur.addr));
                    chk("wrdata", 32'(o_WRDATA), 32'(cur.data));
                end
                h_addr = o_WRADDR;
                h_data = o_WRDATA;
                reqcyc = 0;
            end else if (o_WRREQ) begin
                chk("hold", 32'({o_WRADDR, o_WRDATA}), 32'({h_addr, h_data}));
            end
            if (!o_WRREQ && prev_req)
                chk("req_len", reqcyc, cur.len);
            if (o_WRREQ) reqcyc++;
            wr = o_WRREQ && cur.ack && (reqcyc == cur.len);
            i_WRDONE = wr;
            abort_mon = wr && cur.abrt;
            last_ack = wr && !cur.abrt && (o_WRADDR == 17'd7);
            prev_req = o_WRREQ;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic start_frame();
        i_START = 1'b1;
        @(negedge clk);
        i_START = 1'b0;
        chk("start_busy", 32'(o_BUSY), 1);
        chk("start_ready", 32'(o_PIX_READY), 1);
        chk("start_count", 32'(o_PIX_COUNT), 0);
        chk("start_err", 32'(o_ERR), 0);
        chk("start_addr", 32'(o_WRADDR), 0);
    endtask

    task automatic send(input logic [16:0] addr, input logic [23:0] pix,
                        input bit mode, input logic [11:0] exp, input int len,
                        input bit ack, input bit abrt, input int gap,
                        input bit junk);
        int t;
        t = 0;
        while (!o_PIX_READY && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("ready_wait", 32'(o_PIX_READY), 1);
        if (!o_PIX_READY) return;
        repeat (gap) begin
            i_PIX_VALID = 1'b0;
            @(negedge clk);
        end
        sb.push_back('{addr: addr, data: exp, len: len, ack: ack, abrt: abrt});
        i_PIX_DATA  = pix;
        i_MODE      = mode;
        i_PIX_VALID = 1'b1;
        @(negedge clk);
        if (junk) begin
            i_PIX_DATA = 24'h5A5A5A;
            i_MODE     = ~mode;
        end else begin
            i_PIX_VALID = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (o_BUSY && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("idle_wait", 32'(o_BUSY), 0);
        i_PIX_VALID = 1'b0;
    endtask

    logic [23:0] f1_pix [8] = '{24'hF718A5, 24'hF718A5, 24'hF8F8F8, 24'h070707,
                                24'h123456, 24'h000000, 24'h7F8088, 24'h09A7C8};
    bit          f1_md  [8] = '{0, 1, 1, 1, 0, 1, 1, 1};
    logic [11:0] f1_exp [8] = '{12'hF1A, 12'hF2A, 12'hFFF, 12'h000,
                                12'h135, 12'h000, 12'h889, 12'h1AD};
    logic [23:0] f2_pix [8] = '{24'h1F2F3F, 24'h1F2F3F, 24'hABCDEF, 24'hABCDEF,
                                24'h0000FF, 24'h808080, 24'h777777, 24'h787878};
    bit          f2_md  [8] = '{1, 0, 0, 1, 1, 0, 1, 1};
    logic [11:0] f2_exp [8] = '{12'h234, 12'h123, 12'hACE, 12'hBDF,
                                12'h00F, 12'h888, 12'h777, 12'h888};

    initial begin
        int t;
        i_RST = 1'b1; i_START = 1'b0; i_MODE = 1'b0;
        i_PIX_VALID = 1'b0; i_PIX_DATA = '0; abort_main = 1'b0;
        repeat (3) @(negedge clk);
        i_RST = 1'b0;
        @(negedge clk);
        chk("rst_wrreq", 32'(o_WRREQ), 0);
        chk("rst_ready", 32'(o_PIX_READY), 0);
        chk("rst_busy", 32'(o_BUSY), 0);
        chk("rst_fdone", 32'(o_FRAME_DONE), 0);
        chk("rst_count", 32'(o_PIX_COUNT), 0);
        chk("rst_err", 32'(o_ERR), 0);
        chk("rst_addr", 32'(o_WRADDR), 0);
        chk("rst_data", 32'(o_WRDATA), 0);

        // Frame 1: quantiser vectors, immediate acks.
        start_frame();
        for (int i = 0; i < 8; i++)
            send(17'(i), f1_pix[i], f1_md[i], f1_exp[i], 1, 1, 0, 0, 0);
        wait_idle();
        chk("f1_count", 32'(o_PIX_COUNT), 8);
        chk("f1_fdcnt", fd_cnt, 1);
        chk("f1_addr", 32'(o_WRADDR), 0);

        // Frame 2: 3-cycle acks, valid gaps, junk offered while not ready.
        start_frame();
        for (int i = 0; i < 8; i++)
            send(17'(i), f2_pix[i], f2_md[i], f2_exp[i], 3, 1, 0,
                 (i % 2) * 2, i < 7);
        wait_idle();
        chk("f2_count", 32'(o_PIX_COUNT), 8);
        chk("f2_fdcnt", fd_cnt, 2);

        // Frame 3: abort on the same edge as the 4th ack.
        start_frame();
        for (int i = 0; i < 4; i++)
            send(17'(i), 24'h345678, 0, 12'h357, 1, 1, i == 3, 0, 0);
        repeat (2) @(negedge clk);
        chk("ab_busy", 32'(o_BUSY), 0);
        chk("ab_ready", 32'(o_PIX_READY), 0);
        chk("ab_wrreq", 32'(o_WRREQ), 0);
        chk("ab_count", 32'(o_PIX_COUNT), 3);
        chk("ab_addr", 32'(o_WRADDR), 0);
        chk("ab_fdcnt", fd_cnt, 2);

        // Frame 4: restart from address 0, then no ack -> timeout.
        start_frame();
        send(17'd0, 24'h111111, 1, 12'h111, 1, 1, 0, 0, 0);
        send(17'd1, 24'h222222, 0, 12'h222, 16, 0, 0, 0, 0);
        wait_idle();
        chk("to_err", 32'(o_ERR), 1);
        chk("to_wrreq", 32'(o_WRREQ), 0);
        chk("to_ready", 32'(o_PIX_READY), 0);
        chk("to_count", 32'(o_PIX_COUNT), 1);

        // Frame 5: start clears err; ack on the 16th edge beats the limit.
        start_frame();
        send(17'd0, 24'h333333, 0, 12'h333, 16, 1, 0, 0, 0);
        t = 0;
        while (!o_PIX_READY && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("lim_ready", 32'(o_PIX_READY), 1);
        chk("lim_err", 32'(o_ERR), 0);
        chk("lim_count", 32'(o_PIX_COUNT), 1);
        abort_main = 1'b1;
        @(negedge clk);
        abort_main = 1'b0;
        chk("lim_ab_busy", 32'(o_BUSY), 0);
        chk("lim_ab_count", 32'(o_PIX_COUNT), 1);
        chk("lim_ab_err", 32'(o_ERR), 0);
        repeat (2) @(negedge clk);
        chk("lim_fdcnt", fd_cnt, 2);
        chk("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
